// File: rtl/demux1x8_tdm.sv
// Receive side of the 8:1 TDM serialiser: collects eight valid serial bits
// framed by sof into one word, with a one-cycle ot_vld pulse per completed word.
module demux1x8_tdm #(
  parameter logic MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       vld,
  input  logic       sof,
  output logic [7:0] ot,
  output logic       ot_vld,
  output logic [2:0] sl,
  output logic       err
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] sl_q, sl_d;
  logic [7:0] ot_q, ot_d;
  logic       ot_vld_q, ot_vld_d;
  logic       err_q, err_d;

  // Lane counter always runs 0..7; only the bit position it lands on is mirrored.
  function automatic logic [7:0] put_lane(input logic [7:0] word,
                                          input logic [2:0] lane,
                                          input logic       bit_in);
    logic [2:0] pos;
    logic [7:0] res;
    pos      = MSB_FIRST ? (3'd7 - lane) : lane;
    res      = word;
    res[pos] = bit_in;
    return res;
  endfunction

  // Next-state, shadow assembly and output pulse generation.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    sl_d     = sl_q;
    ot_d     = ot_q;
    ot_vld_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vld && sof) begin
          sh_d    = put_lane(8'h00, 3'd0, din);
          sl_d    = 3'd1;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (vld && sof) begin
          // Early sof: drop the partial frame and restart at lane 0.
          err_d   = 1'b1;
          sh_d    = put_lane(8'h00, 3'd0, din);
          sl_d    = 3'd1;
          state_d = ST_COLLECT;
        end else if (vld) begin
          sh_d = put_lane(sh_q, sl_q, din);
          if (sl_q == 3'd7) begin
            ot_d     = put_lane(sh_q, sl_q, din);
            ot_vld_d = 1'b1;
            sl_d     = 3'd0;
            state_d  = ST_IDLE;
          end else begin
            sl_d = sl_q + 3'd1;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sh_d    = 8'h00;
        sl_d    = 3'd0;
      end
    endcase
  end

  // State and output registers; rst overrides any bit presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sh_q     <= 8'h00;
      sl_q     <= 3'd0;
      ot_q     <= 8'h00;
      ot_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
      ot_q     <= ot_d;
      ot_vld_q <= ot_vld_d;
      err_q    <= err_d;
    end
  end

  assign ot     = ot_q;
  assign ot_vld = ot_vld_q;
  assign sl     = sl_q;
  assign err    = err_q;

endmodule

// File: tb/tb_demux1x8_tdm.sv
// Self-checking bench for demux1x8_tdm: both lane mappings run side by side
// against a frame-level model, plus directed scenarios with literal expectations.
module tb_demux1x8_tdm;

  logic       clk = 1'b0;
  logic       rst, din, vld, sof;
  logic [7:0] ot0, ot1;
  logic       ot_vld0, ot_vld1, err0, err1;
  logic [2:0] sl0, sl1;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pulse_cnt = 0;
  int last_pulse = 0;
  int prev_pulse = 0;

  always #5 clk = ~clk;

  demux1x8_tdm #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .vld(vld), .sof(sof),
    .ot(ot0), .ot_vld(ot_vld0), .sl(sl0), .err(err0)
  );

  demux1x8_tdm #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .vld(vld), .sof(sof),
    .ot(ot1), .ot_vld(ot_vld1), .sl(sl1), .err(err1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Frame-level model: a list of received lane bits and whether a frame is open.
  logic       m_lanes [8];
  int         m_cnt = 0;
  bit         m_open = 1'b0;
  bit         m_ok = 1'b0;
  logic [7:0] e_ot0 = 8'h00, e_ot1 = 8'h00;
  logic       e_vld = 1'b0, e_err = 1'b0;
  logic [2:0] e_sl = 3'd0;

  always @(posedge clk) begin
    logic r_s, v_s, s_s, d_s;
    r_s = rst; v_s = vld; s_s = sof; d_s = din;
    cycle++;
    e_vld = 1'b0;
    e_err = 1'b0;
    if (r_s) begin
      m_ok = 1'b1; m_open = 1'b0; m_cnt = 0;
      e_ot0 = 8'h00; e_ot1 = 8'h00;
    end else if (v_s && s_s) begin
      e_err = m_open;
      m_open = 1'b1; m_lanes[0] = d_s; m_cnt = 1;
    end else if (v_s && m_open) begin
      m_lanes[m_cnt] = d_s;
      m_cnt++;
      if (m_cnt == 8) begin
        for (int k = 0; k < 8; k++) begin
          e_ot0[k]     = m_lanes[k];
          e_ot1[7 - k] = m_lanes[k];
        end
        e_vld = 1'b1; m_open = 1'b0; m_cnt = 0;
      end
    end
    e_sl = 3'(m_cnt);
    #1;
    if (m_ok) begin
      chk("ot0", ot0, e_ot0);
      chk("ot1", ot1, e_ot1);
      chk("ot_vld0", {7'd0, ot_vld0}, {7'd0, e_vld});
      chk("ot_vld1", {7'd0, ot_vld1}, {7'd0, e_vld});
      chk("err0", {7'd0, err0}, {7'd0, e_err});
      chk("err1", {7'd0, err1}, {7'd0, e_err});
      chk("sl0", {5'd0, sl0}, {5'd0, e_sl});
      chk("sl1", {5'd0, sl1}, {5'd0, e_sl});
    end
    if (ot_vld0 === 1'b1) begin
      prev_pulse = last_pulse;
      last_pulse = cycle;
      pulse_cnt++;
    end
  end

  task automatic drive(input logic r, input logic v, input logic s, input logic d);
    @(negedge clk);
    rst = r; vld = v; sof = s; din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_word(input logic [7:0] w, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) repeat ($urandom_range(0, maxgap)) idle();
      drive(1'b0, 1'b1, (i == 0), w[i]);
    end
  endtask

  initial begin
    int p;
    logic [7:0] w;
    rst = 1'b1; vld = 1'b0; sof = 1'b0; din = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_ot", ot0, 8'h00);
    chk("rst_sl", {5'd0, sl0}, 8'h00);
    chk("rst_vld", {7'd0, ot_vld0}, 8'h00);
    chk("rst_err", {7'd0, err0}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      chk("idle_ot", ot0, 8'h00);
      chk("idle_sl", {5'd0, sl0}, 8'h00);
      chk("idle_vld", {7'd0, ot_vld0}, 8'h00);
    end

    // Lane order 1,0,1,1,0,0,1,0.
    w = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, (i == 0), w[i]);
      chk("basic_sl", {5'd0, sl0}, 8'((i + 1) % 8));
    end
    chk("basic_ot0", ot0, 8'h4D);
    chk("basic_ot1", ot1, 8'hB2);
    chk("basic_vld", {7'd0, ot_vld0}, 8'h01);
    idle();
    chk("basic_vld_low", {7'd0, ot_vld0}, 8'h00);
    chk("basic_hold", ot0, 8'h4D);

    p = pulse_cnt;
    send_word(8'hA5, 5);
    idle();
    chk("gap_ot", ot0, 8'hA5);
    chk("gap_pulses", 8'(pulse_cnt - p), 8'h01);

    w = 8'h3C;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, (i == 0), 1'($urandom_range(0, 1)));
    drive(1'b0, 1'b1, 1'b1, w[0]);
    chk("early_err", {7'd0, err0}, 8'h01);
    chk("early_ot", ot0, 8'hA5);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, w[i]);
      if (i == 1) chk("early_err_low", {7'd0, err0}, 8'h00);
    end
    chk("early_ot_3c", ot0, 8'h3C);

    p = pulse_cnt;
    send_word(8'hFF, 0);
    chk("b2b_ff", ot0, 8'hFF);
    send_word(8'h00, 0);
    chk("b2b_pulses", 8'(pulse_cnt - p), 8'h02);
    chk("b2b_spacing", 8'(last_pulse - prev_pulse), 8'h08);
    chk("b2b_00", ot0, 8'h00);

    p = pulse_cnt;
    w = 8'h5A;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, (i == 0), w[i]);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mrst_ot", ot0, 8'h00);
    chk("mrst_sl", {5'd0, sl0}, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("mrst_restart_sl", {5'd0, sl0}, 8'h01);
    repeat (10) idle();
    chk("mrst_no_pulse", 8'(pulse_cnt - p), 8'h00);

    repeat (3000) begin
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1x8_tdm.md
# demux1x8_tdm

Time-division 1-to-8 demultiplexer: the receive end of the 8:1 mux serialiser used on the team's lab boards. It takes a serial bit stream framed by a start-of-frame strobe, steers each valid bit into lane 0..7 under an internal 3-bit lane counter, and presents the assembled 8-bit word with a one-cycle valid pulse. It sits directly behind the serial link, in the same clock domain as the sender.

## Interface
- MSB_FIRST, default 0: lane-to-bit mapping.
  - 0: the lane-0 bit (the one carrying sof) lands in ot[0].
  - 1: the lane-0 bit lands in ot[7].
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- din  input  1  serial data bit.
- vld  input  1  din is valid this cycle.
- sof  input  1  start of frame. Only meaningful with vld=1; marks din as lane 0.
- ot  output  8  last complete word, registered.
- ot_vld  output  1  one-cycle pulse: ot was updated this cycle.
- sl  output  3  lane index the next valid bit will be written to.
- err  output  1  one-cycle pulse: a frame was aborted by an early sof.

## Operation
- **State machine:** two states, IDLE and COLLECT. An internal 8-bit shadow register sh holds bits as they arrive.
- **Reset (rst=1 at a clock edge):**
  - state=IDLE, sh=0, sl=0.
  - ot=8'h00, ot_vld=0, err=0.
  - rst takes priority over all other inputs.
- **IDLE:**
  - vld=0, or vld=1 with sof=0: the bit is ignored and nothing changes.
  - vld=1 with sof=1:
    - sh is cleared, then din is written to lane 0.
    - sl becomes 1 and the state moves to COLLECT.
- **COLLECT:**
  - vld=0: hold. No timeout; gaps of any length are allowed.
  - vld=1, sof=0: din is written to lane sl.
    - If sl<7: sl increments.
    - If sl=7:
      - ot is loaded with sh plus this bit, and ot_vld pulses.
      - sl wraps to 0 and the state returns to IDLE.
  - vld=1, sof=1 (any sl, since sl is always 1..7 in COLLECT):
    - The partial frame is discarded and err pulses.
    - sh is cleared and din is written to lane 0; sl becomes 1 and the state stays COLLECT.
    - ot is not modified.
- **Lane mapping:**
  - MSB_FIRST=0: lane k maps to bit k.
  - MSB_FIRST=1: lane k maps to bit 7-k.
  - sl always counts lanes 0..7, regardless of mapping.
- **Output hold:**
  - ot holds its value between completions.
  - ot_vld and err are never high for more than one consecutive cycle per event.
- **Back-to-back frames:** a sof on the cycle right after the 8th bit is accepted (the state is IDLE by then). Continuous streaming therefore delivers one word every 8 valid cycles.
- **sof with vld=0:** ignored in both states.

## Timing
- **Word latency:** 8th bit sampled at edge N → ot and ot_vld=1 visible after edge N, i.e. during cycle N+1. ot_vld returns to 0 after edge N+1 unless another frame completes then, which is impossible with 8-bit frames.
- **Error latency:** early sof sampled at edge N → err=1 during cycle N+1.
- **sl:** registered; it updates at the same edge that consumes the bit.
- **Throughput:** at most one bit per cycle; no backpressure, since vld is never stalled.
- **Reset mid-frame:** rst at edge N.
  - From cycle N+1, all outputs are at their reset values and any partial frame is lost.
  - A vld+sof on cycle N+1 starts a new frame normally.
- **Simultaneous rst and vld/sof:** rst wins and the bit is dropped.

## Test plan
- **Reset values:** drive rst=1 for 2 cycles, then release → ot=8'h00, ot_vld=0, err=0, sl=0. vld=1, sof=0 pulses while IDLE leave all outputs unchanged.
- **Basic frame, MSB_FIRST=0:** send bits 1,0,1,1,0,0,1,0 with sof on the first and vld continuous → ot=8'h4D, ot_vld high exactly one cycle after the 8th bit, sl sequence 1..7 then 0.
- **MSB_FIRST=1:** same bit stream → ot=8'hB2.
- **Gapped input:** insert vld=0 gaps of 0–5 cycles between bits of 8'hA5 → ot=8'hA5, with a single ot_vld pulse.
- **Early sof:** after 5 bits, assert vld+sof → err pulses once and ot is unchanged. Completing a full 8-bit frame from that sof (3C) then gives ot=8'h3C.
- **Back-to-back and reset:**
  - Two consecutive frames 8'hFF then 8'h00 with no idle cycle → two ot_vld pulses exactly 8 cycles apart.
  - rst asserted at bit 4 of a third frame → no ot_vld for that frame, and ot=8'h00.
